// File: rtl/sdram_ch2_bridge.sv
// sdram_ch2_bridge
// 32-bit CPU bus front end for the SDRAM controller's 16-bit channel 2 port.
// Each bus access becomes one or two halfword accesses (H0 = bits 31:16 at the
// even halfword, H1 = bits 15:0 at the odd halfword). Strobes are held until
// the controller reports completion, then dropped for a gap so that the next
// half produces a fresh rising edge.
// Optional feature: define SDRAM_CH2_BRIDGE_RDCACHE_EN for a one-entry read
// cache that answers repeated reads of the same word without ch2 traffic.
module sdram_ch2_bridge #(
    parameter int RD_DATA_DELAY = 16,
    parameter int GAP_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [19:0] bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_din,
    output logic [31:0] bus_dout,
    output logic        bus_ack,
    output logic [20:0] ch2addr,
    output logic [15:0] ch2din,
    output logic [1:0]  ch2wr,
    output logic        ch2rd,
    input  logic [15:0] ch2dout,
    input  logic        ch2rdy
);

    localparam int CNT_W = $clog2(RD_DATA_DELAY + GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RD_DLY    = 3'd4,
        S_GAP       = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t             state;
    logic [19:0]        addr_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        din_q;
    logic               half_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rd_hit;

    // Byte-enable pair belonging to the selected half (H0 uses the upper pair).
    function automatic logic [1:0] half_be(input logic [3:0] be, input logic half);
        return half ? be[1:0] : be[3:2];
    endfunction

`ifdef SDRAM_CH2_BRIDGE_RDCACHE_EN
    logic               cache_valid;
    logic [19:0]        cache_addr;
    logic [31:0]        cache_data;

    // Overlay the enabled bytes of new_d onto old_d.
    function automatic logic [31:0] be_merge(input logic [31:0] old_d,
                                             input logic [31:0] new_d,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_d;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_d[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_d[i*8 +: 8];
            end
        end
        return res;
    endfunction

    assign rd_hit = cache_valid && (cache_addr == bus_addr);
`else
    assign rd_hit = 1'b0;
`endif

    // Access sequencer: accepts bus requests, walks the halves through the ch2
    // handshake and produces the registered strobes, read data and ack pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            addr_q   <= 20'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            din_q    <= 32'd0;
            half_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            bus_ack  <= 1'b0;
            bus_dout <= 32'd0;
            ch2addr  <= 21'd0;
            ch2din   <= 16'd0;
            ch2wr    <= 2'b00;
            ch2rd    <= 1'b0;
`ifdef SDRAM_CH2_BRIDGE_RDCACHE_EN
            cache_valid <= 1'b0;
            cache_addr  <= 20'd0;
            cache_data  <= 32'd0;
`endif
        end else begin
            bus_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    // bus_ack=1 here means the ack cycle: the held request is not re-accepted.
                    if (bus_req && !bus_ack) begin
                        addr_q <= bus_addr;
                        we_q   <= bus_we;
                        be_q   <= bus_be;
                        din_q  <= bus_din;
                        cnt_q  <= {CNT_W{1'b0}};
                        if (!bus_we && rd_hit) begin
`ifdef SDRAM_CH2_BRIDGE_RDCACHE_EN
                            bus_dout <= cache_data;
`endif
                            bus_ack <= 1'b1;
                            state   <= S_IDLE;
                        end else if (!bus_we || (bus_be[3:2] != 2'b00)) begin
                            half_q <= 1'b0;
                            state  <= S_ISSUE;
                        end else if (bus_be[1:0] != 2'b00) begin
                            half_q <= 1'b1;
                            state  <= S_ISSUE;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    ch2addr <= {addr_q, half_q};
                    ch2din  <= half_q ? din_q[15:0] : din_q[31:16];
                    if (we_q) begin
                        ch2wr <= half_be(be_q, half_q);
                        ch2rd <= 1'b0;
                    end else begin
                        ch2wr <= 2'b00;
                        ch2rd <= 1'b1;
                    end
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // ch2rdy may still be high from before the strobe was seen.
                    if (!ch2rdy) begin
                        state <= S_WAIT_DONE;
                    end else begin
                        state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_DONE: begin
                    if (ch2rdy) begin
                        ch2rd <= 1'b0;
                        ch2wr <= 2'b00;
                        cnt_q <= {CNT_W{1'b0}};
                        if (!we_q) begin
                            state <= S_RD_DLY;
                        end else if (!half_q && (be_q[1:0] != 2'b00)) begin
                            half_q <= 1'b1;
                            state  <= S_GAP;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_RD_DLY: begin
                    if (cnt_q == CNT_W'(RD_DATA_DELAY - 1)) begin
                        cnt_q <= {CNT_W{1'b0}};
                        if (half_q) begin
                            bus_dout[15:0] <= ch2dout;
                            state          <= S_DONE;
                        end else begin
                            bus_dout[31:16] <= ch2dout;
                            half_q          <= 1'b1;
                            state           <= S_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        state <= S_RD_DLY;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_q <= {CNT_W{1'b0}};
                        state <= S_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        state <= S_GAP;
                    end
                end
                S_DONE: begin
                    bus_ack <= 1'b1;
                    state   <= S_IDLE;
`ifdef SDRAM_CH2_BRIDGE_RDCACHE_EN
                    if (!we_q) begin
                        cache_valid <= 1'b1;
                        cache_addr  <= addr_q;
                        cache_data  <= bus_dout;
                    end else if (cache_valid && (cache_addr == addr_q)) begin
                        cache_data <= be_merge(cache_data, din_q, be_q);
                    end else begin
                        cache_data <= cache_data;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    ch2rd <= 1'b0;
                    ch2wr <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ch2_bridge.sv
// Self-checking bench for sdram_ch2_bridge: a negedge ch2 controller model
// checks every strobe against a queue of expected halfword transactions, and
// bus tasks compare read data at ack against a queue of expected words.
module tb_sdram_ch2_bridge;

    localparam int RDD = 16;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req;
    logic        bus_we;
    logic [19:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_din;
    logic [31:0] bus_dout;
    logic        bus_ack;
    logic [20:0] ch2addr;
    logic [15:0] ch2din;
    logic [1:0]  ch2wr;
    logic        ch2rd;
    logic [15:0] ch2dout;
    logic        ch2rdy;

    always #5 clk = ~clk;

    sdram_ch2_bridge #(.RD_DATA_DELAY(RDD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_ack(bus_ack),
        .ch2addr(ch2addr), .ch2din(ch2din), .ch2wr(ch2wr), .ch2rd(ch2rd),
        .ch2dout(ch2dout), .ch2rdy(ch2rdy)
    );

    typedef struct packed {
        logic [20:0] addr;
        logic        rd;
        logic [1:0]  wr;
        logic [15:0] din;
    } ch2_txn_t;

    int          checks = 0;
    int          failures = 0;
    ch2_txn_t    ch2_q[$];
    logic [31:0] dout_q[$];
    logic [31:0] exp_dout = 32'd0;
    logic [15:0] mem [0:255];

    // controller model state
    int          pre_hold = 0;
    int          svc = 3;
    bit          abort_ok = 1'b0;
    int          edge_cnt = 0;
    int          access_edges = 0;
    int          low_run = 0;
    int          m_phase = 0;     // 0 idle, 1 rdy still high, 2 busy
    int          m_cnt = 0;
    ch2_txn_t    m_cur;
    ch2_txn_t    m_exp;
    logic        strobe;
    logic        prev_strobe = 1'b0;

    function automatic ch2_txn_t mk(input logic [20:0] a, input logic rd,
                                    input logic [1:0] wr, input logic [15:0] d);
        ch2_txn_t t;
        t.addr = a; t.rd = rd; t.wr = wr; t.din = d;
        return t;
    endfunction

    // ch2 controller model: detects strobe edges, plays the ch2rdy handshake and
    // checks each half against the expected transaction queue.
    always @(negedge clk) begin
        strobe = ch2rd | (ch2wr != 2'b00);
        case (m_phase)
            1: begin
                m_cnt--;
                if (m_cnt == 0) begin ch2rdy = 1'b0; m_phase = 2; m_cnt = svc; end
            end
            2: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    ch2rdy = 1'b1;
                    if (m_cur.wr[1]) mem[m_cur.addr[7:0]][15:8] = m_cur.din[15:8];
                    if (m_cur.wr[0]) mem[m_cur.addr[7:0]][7:0]  = m_cur.din[7:0];
                    if (m_cur.rd) ch2dout = mem[m_cur.addr[7:0]];
                    m_phase = 0;
                end
            end
            default: ;
        endcase
        if (strobe === 1'b1 && prev_strobe === 1'b0) begin
            edge_cnt++;
            checks++;
            if (ch2_q.size() == 0) begin
                failures++;
                $display("FAIL ch2_unexpected got addr=%h rd=%b wr=%b din=%h, required no strobe",
                         ch2addr, ch2rd, ch2wr, ch2din);
            end else begin
                m_exp = ch2_q.pop_front();
                if (ch2addr !== m_exp.addr || ch2rd !== m_exp.rd || ch2wr !== m_exp.wr ||
                    (m_exp.wr != 2'b00 && ch2din !== m_exp.din)) begin
                    failures++;
                    $display("FAIL ch2_txn got addr=%h rd=%b wr=%b din=%h, required addr=%h rd=%b wr=%b din=%h",
                             ch2addr, ch2rd, ch2wr, ch2din, m_exp.addr, m_exp.rd, m_exp.wr, m_exp.din);
                end
            end
            if (access_edges > 0) begin
                checks++;
                if (low_run < GAP) begin
                    failures++;
                    $display("FAIL strobe_gap got %0d low cycles, required >= %0d", low_run, GAP);
                end
            end
            access_edges++;
            m_cur = mk(ch2addr, ch2rd, ch2wr, ch2din);
            if (pre_hold == 0) begin ch2rdy = 1'b0; m_phase = 2; m_cnt = svc; end
            else begin m_phase = 1; m_cnt = pre_hold; end
            low_run = 0;
        end else if (strobe === 1'b0 && prev_strobe === 1'b1) begin
            if (!abort_ok) begin
                checks++;
                if (m_phase != 0) begin
                    failures++;
                    $display("FAIL early_drop strobe dropped in model phase %0d, required phase 0", m_phase);
                end
            end
        end else if (strobe === 1'b1 && m_phase != 0) begin
            checks++;
            if (ch2addr !== m_cur.addr || ch2wr !== m_cur.wr ||
                (m_cur.wr != 2'b00 && ch2din !== m_cur.din)) begin
                failures++;
                $display("FAIL ch2_stable got addr=%h wr=%b din=%h, required addr=%h wr=%b din=%h",
                         ch2addr, ch2wr, ch2din, m_cur.addr, m_cur.wr, m_cur.din);
            end
        end
        if (strobe !== 1'b1) low_run++;
        prev_strobe = (strobe === 1'b1);
    end

    // Drive one bus access, wait (bounded) for the ack, compare data, check pulse width.
    task automatic do_access(input logic we, input logic [19:0] addr, input logic [3:0] be,
                             input logic [31:0] din, output int cyc);
        bit got;
        logic [31:0] exp;
        access_edges = 0;
        @(negedge clk);
        bus_we = we; bus_addr = addr; bus_be = be; bus_din = din; bus_req = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_ack === 1'b1) got = 1'b1;
        end
        bus_req = 1'b0;
        exp = dout_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ack_timeout addr=%h got no ack in %0d cycles, required ack", addr, cyc);
        end else if (bus_dout !== exp) begin
            failures++;
            $display("FAIL bus_dout addr=%h got %h, required %h", addr, bus_dout, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_width got bus_ack=%b one cycle after ack, required 0", bus_ack);
        end
    endtask

    task automatic check_edges(input string name, input int e0, input int want);
        checks++;
        if (edge_cnt - e0 != want || ch2_q.size() != 0) begin
            failures++;
            $display("FAIL %s_edges got %0d strobes (%0d pending), required %0d (0 pending)",
                     name, edge_cnt - e0, ch2_q.size(), want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 20'd0; bus_be = 4'd0; bus_din = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_ack !== 1'b0 || bus_dout !== 32'd0 || ch2rd !== 1'b0 || ch2wr !== 2'b00 ||
            ch2addr !== 21'd0 || ch2din !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got ack=%b dout=%h rd=%b wr=%b addr=%h din=%h, required all 0",
                     bus_ack, bus_dout, ch2rd, ch2wr, ch2addr, ch2din);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_write();
        int e0, cyc;
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00020, 1'b0, 2'b11, 16'hA1B2));
        ch2_q.push_back(mk(21'h00021, 1'b0, 2'b11, 16'hC3D4));
        dout_q.push_back(exp_dout);
        do_access(1'b1, 20'h00010, 4'b1111, 32'hA1B2C3D4, cyc);
        check_edges("write_full", e0, 2);
        checks++;
        if (mem[8'h20] !== 16'hA1B2 || mem[8'h21] !== 16'hC3D4) begin
            failures++;
            $display("FAIL write_full_mem got %h %h, required a1b2 c3d4", mem[8'h20], mem[8'h21]);
        end
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00023, 1'b0, 2'b11, 16'h3344));
        dout_q.push_back(exp_dout);
        do_access(1'b1, 20'h00011, 4'b0011, 32'h11223344, cyc);
        check_edges("write_low", e0, 1);
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00024, 1'b0, 2'b10, 16'h5566));
        ch2_q.push_back(mk(21'h00025, 1'b0, 2'b01, 16'h7788));
        dout_q.push_back(exp_dout);
        do_access(1'b1, 20'h00012, 4'b1001, 32'h55667788, cyc);
        check_edges("write_mixed", e0, 2);
        checks++;
        if (mem[8'h24] !== 16'h5500 || mem[8'h25] !== 16'h0088) begin
            failures++;
            $display("FAIL write_mixed_mem got %h %h, required 5500 0088", mem[8'h24], mem[8'h25]);
        end
        e0 = edge_cnt;
        dout_q.push_back(exp_dout);
        do_access(1'b1, 20'h00013, 4'b0000, 32'hFFFFFFFF, cyc);
        check_edges("write_none", e0, 0);
        checks++;
        if (cyc != 2) begin
            failures++;
            $display("FAIL write_none_latency got %0d cycles, required 2", cyc);
        end
    endtask

    task automatic test_read();
        int e0, cyc;
        mem[8'h40] = 16'hDEAD; mem[8'h41] = 16'hBEEF;
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00040, 1'b1, 2'b00, 16'h0000));
        ch2_q.push_back(mk(21'h00041, 1'b1, 2'b00, 16'h0000));
        exp_dout = 32'hDEADBEEF;
        dout_q.push_back(exp_dout);
        do_access(1'b0, 20'h00020, 4'b0000, 32'h0, cyc);
        check_edges("read", e0, 2);
        checks++;
        if (cyc < 2 * RDD + GAP) begin
            failures++;
            $display("FAIL read_latency got %0d cycles, required >= %0d", cyc, 2 * RDD + GAP);
        end
    endtask

    task automatic test_slow_ack();
        int e0, cyc;
        pre_hold = 5; svc = 20;
        mem[8'h60] = 16'h1234; mem[8'h61] = 16'h5678;
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00060, 1'b1, 2'b00, 16'h0000));
        ch2_q.push_back(mk(21'h00061, 1'b1, 2'b00, 16'h0000));
        exp_dout = 32'h12345678;
        dout_q.push_back(exp_dout);
        do_access(1'b0, 20'h00030, 4'b1111, 32'h0, cyc);
        check_edges("slow_read", e0, 2);
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00062, 1'b0, 2'b11, 16'h0BAD));
        ch2_q.push_back(mk(21'h00063, 1'b0, 2'b11, 16'hF00D));
        dout_q.push_back(exp_dout);
        do_access(1'b1, 20'h00031, 4'b1111, 32'h0BADF00D, cyc);
        check_edges("slow_write", e0, 2);
        checks++;
        if (cyc < 2 * (5 + 20)) begin
            failures++;
            $display("FAIL slow_write_latency got %0d cycles, required >= 50", cyc);
        end
        pre_hold = 0; svc = 3;
    endtask

    task automatic test_reset_mid();
        int e0, cyc;
        bit ack_seen;
        svc = 30;
        mem[8'h70] = 16'h7777;
        ch2_q.push_back(mk(21'h00070, 1'b1, 2'b00, 16'h0000));
        access_edges = 0;
        @(negedge clk);
        bus_we = 1'b0; bus_addr = 20'h00038; bus_be = 4'b1111; bus_req = 1'b1;
        for (int i = 0; i < 200 && m_phase != 2; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        reset = 1'b1; bus_req = 1'b0; abort_ok = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ch2rd !== 1'b0 || ch2wr !== 2'b00 || bus_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got rd=%b wr=%b ack=%b, required 0 0 0", ch2rd, ch2wr, bus_ack);
        end
        @(negedge clk); reset = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 200 && m_phase != 0; i++) begin
            @(negedge clk);
            if (bus_ack === 1'b1) ack_seen = 1'b1;
        end
        repeat (RDD + 4) begin
            @(negedge clk);
            if (bus_ack === 1'b1) ack_seen = 1'b1;
        end
        checks++;
        if (ack_seen || ch2_q.size() != 0 || bus_dout !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_after got ack_seen=%b pending=%0d dout=%h, required 0 0 0",
                     ack_seen, ch2_q.size(), bus_dout);
        end
        abort_ok = 1'b0; svc = 3;
        exp_dout = 32'd0;
        mem[8'h72] = 16'hCAFE; mem[8'h73] = 16'hF00D;
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00072, 1'b1, 2'b00, 16'h0000));
        ch2_q.push_back(mk(21'h00073, 1'b1, 2'b00, 16'h0000));
        exp_dout = 32'hCAFEF00D;
        dout_q.push_back(exp_dout);
        do_access(1'b0, 20'h00039, 4'b0000, 32'h0, cyc);
        check_edges("post_reset_read", e0, 2);
    endtask

    task automatic test_req_drop();
        int e0, cyc;
        bit got;
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00080, 1'b0, 2'b11, 16'h9999));
        access_edges = 0;
        @(negedge clk);
        bus_we = 1'b1; bus_addr = 20'h00040; bus_be = 4'b1100; bus_din = 32'h99990000; bus_req = 1'b1;
        for (int i = 0; i < 200 && edge_cnt == e0; i++) @(negedge clk);
        bus_req = 1'b0;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || bus_dout !== exp_dout) begin
            failures++;
            $display("FAIL req_drop got ack=%b dout=%h, required ack=1 dout=%h", got, bus_dout, exp_dout);
        end
        check_edges("req_drop", e0, 1);
    endtask

`ifdef SDRAM_CH2_BRIDGE_RDCACHE_EN
    task automatic test_rdcache();
        int e0, cyc;
        mem[8'h00] = 16'h1122; mem[8'h01] = 16'h3344;
        e0 = edge_cnt;
        ch2_q.push_back(mk(21'h00200, 1'b1, 2'b00, 16'h0000));
        ch2_q.push_back(mk(21'h00201, 1'b1, 2'b00, 16'h0000));
        exp_dout = 32'h11223344;
        dout_q.push_back(exp_dout);
        do_access(1'b0, 20'h00100, 4'b1111, 32'h0, cyc);
        ch2_q.push_back(mk(21'h00200, 1'b0, 2'b10, 16'hFF00));
        dout_q.push_back(exp_dout);
        do_access(1'b1, 20'h00100, 4'b1000, 32'hFF000000, cyc);
        check_edges("cache_fill", e0, 3);
        e0 = edge_cnt;
        exp_dout = 32'hFF223344;
        dout_q.push_back(exp_dout);
        do_access(1'b0, 20'h00100, 4'b1111, 32'h0, cyc);
        check_edges("cache_hit", e0, 0);
        checks++;
        if (cyc != 1) begin
            failures++;
            $display("FAIL cache_hit_latency got %0d cycles, required 1", cyc);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        ch2rdy = 1'b1; ch2dout = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_slow_ack();
        test_req_drop();
        test_reset_mid();
`ifdef SDRAM_CH2_BRIDGE_RDCACHE_EN
        test_rdcache();
`endif
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
